spi_device_core: RTL and testbench

//  SPI slave (device) core, the far end of the SPI host link: receives characters shifted
//  in by an external master on sclk_i/sd_i and returns characters on sd_o. It sits behind
//  the same TL-UL register adapter as the host core. All SPI inputs are synchronised into clk_i.
//  It raises intr_rx_o per received char and intr_tx_o when the TX holding register empties.

---
 rtl/spi_device_core.sv | 259 +++++++++++++++++++++++++
 tb/tb_spi_device_core.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_device_core.sv
// rtl/spi_device_core.sv - SPI slave core: register file, synchronised SPI inputs, char shifter, interrupts
module spi_device_core #(
    parameter int MAX_CHAR = 32,
    parameter int LEN_W    = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic [3:0]  be_i,
    input  logic        we_i,
    input  logic        re_i,
    output logic        error_o,
    output logic        intr_rx_o,
    output logic        intr_tx_o,
    input  logic        ss_ni,
    input  logic        sclk_i,
    input  logic        sd_i,
    output logic        sd_o,
    output logic        sd_oe_o
);

    localparam logic [2:0] REG_RX     = 3'd0;
    localparam logic [2:0] REG_TX     = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;

    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    state_t state, state_next;

    // synchronisers; ss idles high so its chain resets to 1
    logic ss_q1, ss_q2, ss_q3;
    logic sclk_q1, sclk_q2, sclk_q3;
    logic sd_q1, sd_q2;

    // control fields
    logic [LEN_W-1:0] char_len;
    logic             en, rx_neg, tx_neg, lsb, ie;

    // data path
    logic [MAX_CHAR-1:0] tx_hold, shift_tx, shift_rx, rx_data;
    logic [MAX_CHAR-1:0] rx_shifted, rx_mask, sd_vec;
    logic [LEN_W-1:0]    bit_cnt, len_m1;
    logic                sampled_any;
    logic                tx_zero;

    // status flags
    logic rx_full, tx_empty, rx_ovf, tx_under;

    logic [2:0]  reg_sel;
    logic        wr, active;
    logic        sclk_rise, sclk_fall, sample_ev, drive_ev, ss_fall;
    logic        start, run, char_done, tx_load, under_set;
    logic        tx_write, ctrl_write, stat_write, rx_read;
    logic [31:0] ctrl_rd, rdata_next;
    logic        unused_addr;

    assign unused_addr = ^{addr_i[7:5], addr_i[1:0]};
    assign error_o     = 1'b0;

    assign reg_sel    = addr_i[4:2];
    assign wr         = we_i & ~re_i;
    assign active     = (state == ST_SHIFT);
    assign tx_write   = wr & (reg_sel == REG_TX);
    assign ctrl_write = wr & (reg_sel == REG_CTRL) & ~active;
    assign stat_write = wr & (reg_sel == REG_STATUS) & be_i[0];
    assign rx_read    = re_i & (reg_sel == REG_RX);

    assign sclk_rise = sclk_q2 & ~sclk_q3;
    assign sclk_fall = ~sclk_q2 & sclk_q3;
    assign sample_ev = rx_neg ? sclk_fall : sclk_rise;
    assign drive_ev  = tx_neg ? sclk_fall : sclk_rise;
    assign ss_fall   = ss_q3 & ~ss_q2;

    // CHAR_LEN=0 wraps to MAX_CHAR-1, i.e. a full MAX_CHAR-bit character
    assign len_m1  = char_len - LEN_W'(1);
    assign rx_mask = ~(({MAX_CHAR{1'b1}} << len_m1) << 1);
    assign sd_vec  = {{(MAX_CHAR-1){1'b0}}, sd_q2};

    // start: IDLE->SHIFT this cycle; run: stays in SHIFT (an aborting cycle does no shifting)
    assign start     = (state == ST_IDLE) & (state_next == ST_SHIFT);
    assign run       = (state == ST_SHIFT) & (state_next == ST_SHIFT);
    assign char_done = run & sample_ev & (bit_cnt == len_m1);
    assign tx_load   = start | char_done;
    // underrun is flagged once an empty-sourced char actually starts clocking out
    assign under_set = run & sample_ev & (bit_cnt == '0) & tx_zero;

    // receive shift: MSB-first enters at bit 0, LSB-first enters at the top of the char
    always_comb begin
        rx_shifted = '0;
        if (lsb) begin
            rx_shifted = (shift_rx >> 1) | (sd_vec << len_m1);
        end else begin
            rx_shifted = {shift_rx[MAX_CHAR-2:0], sd_q2};
        end
    end

    // two-flop synchronisers, third sclk flop for edge detection, third ss flop for fall detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ss_q1   <= 1'b1;
            ss_q2   <= 1'b1;
            ss_q3   <= 1'b1;
            sclk_q1 <= 1'b0;
            sclk_q2 <= 1'b0;
            sclk_q3 <= 1'b0;
            sd_q1   <= 1'b0;
            sd_q2   <= 1'b0;
        end else begin
            ss_q1   <= ss_ni;
            ss_q2   <= ss_q1;
            ss_q3   <= ss_q2;
            sclk_q1 <= sclk_i;
            sclk_q2 <= sclk_q1;
            sclk_q3 <= sclk_q2;
            sd_q1   <= sd_i;
            sd_q2   <= sd_q1;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: enter on a select fall while enabled, leave on deselect or disable
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (ss_fall && en) state_next = ST_SHIFT;
            ST_SHIFT: if (ss_q2 || !en) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: MISO driven only while shifting
    always_comb begin
        sd_oe_o = 1'b0;
        sd_o    = 1'b0;
        if (state == ST_SHIFT) begin
            sd_oe_o = 1'b1;
            sd_o    = lsb ? shift_tx[0] : shift_tx[len_m1];
        end
    end

    // control register, frozen while a frame is active
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            char_len <= '0;
            en       <= 1'b0;
            rx_neg   <= 1'b0;
            tx_neg   <= 1'b0;
            lsb      <= 1'b0;
            ie       <= 1'b0;
        end else if (ctrl_write) begin
            if (be_i[0]) char_len <= wdata_i[LEN_W-1:0];
            if (be_i[1]) {ie, lsb, tx_neg, rx_neg, en} <= wdata_i[12:8];
        end
    end

    // TX holding register, byte-enabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_hold <= '0;
        end else if (tx_write) begin
            for (int i = 0; i < MAX_CHAR / 8; i++) begin
                if (be_i[i]) tx_hold[8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // character shifter: (re)load at char boundaries, sample/drive on the selected sclk edges
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt     <= '0;
            shift_tx    <= '0;
            shift_rx    <= '0;
            sampled_any <= 1'b0;
            tx_zero     <= 1'b0;
        end else if (tx_load) begin
            bit_cnt     <= '0;
            shift_rx    <= '0;
            sampled_any <= 1'b0;
            tx_zero     <= tx_empty;
            shift_tx    <= tx_empty ? '0 : tx_hold;
        end else if (run) begin
            if (sample_ev) begin
                shift_rx    <= rx_shifted;
                bit_cnt     <= bit_cnt + LEN_W'(1);
                sampled_any <= 1'b1;
            end
            // the drive edge preceding the first sample of a char would skip bit 0
            if (drive_ev && sampled_any) begin
                shift_tx <= lsb ? (shift_tx >> 1) : (shift_tx << 1);
            end
        end
    end

    // RX register and status flags; hardware set wins over software clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_data  <= '0;
            rx_full  <= 1'b0;
            tx_empty <= 1'b1;
            rx_ovf   <= 1'b0;
            tx_under <= 1'b0;
        end else begin
            if (char_done) rx_data <= rx_shifted & rx_mask;

            if (rx_read || (stat_write && wdata_i[0])) rx_full <= 1'b0;
            if (char_done) rx_full <= 1'b1;

            if (stat_write && wdata_i[2]) rx_ovf <= 1'b0;
            if (char_done && rx_full && !rx_read) rx_ovf <= 1'b1;

            if (stat_write && wdata_i[1]) tx_empty <= 1'b0;
            if (tx_load) tx_empty <= 1'b1;
            if (tx_write) tx_empty <= 1'b0;

            if (stat_write && wdata_i[3]) tx_under <= 1'b0;
            if (under_set) tx_under <= 1'b1;
        end
    end

    // read mux
    always_comb begin
        ctrl_rd                = '0;
        ctrl_rd[LEN_W-1:0]     = char_len;
        ctrl_rd[12:8]          = {ie, lsb, tx_neg, rx_neg, en};
        rdata_next             = '0;
        case (reg_sel)
            REG_RX:     rdata_next = 32'(rx_data);
            REG_TX:     rdata_next = 32'(tx_hold);
            REG_CTRL:   rdata_next = ctrl_rd;
            REG_STATUS: rdata_next = {27'd0, active, tx_under, rx_ovf, tx_empty, rx_full};
            default:    rdata_next = '0;
        endcase
    end

    // registered read data and interrupt pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o   <= '0;
            intr_rx_o <= 1'b0;
            intr_tx_o <= 1'b0;
        end else begin
            rdata_o   <= rdata_next;
            intr_rx_o <= ie & char_done;
            intr_tx_o <= ie & tx_load & ~tx_empty;
        end
    end

endmodule

// File: tb/tb_spi_device_core.sv
// tb/tb_spi_device_core.sv - self-checking bench for spi_device_core with a frame-level reference model
module tb_spi_device_core;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic [3:0]  be_i = '0;
    logic        we_i = 1'b0;
    logic        re_i = 1'b0;
    logic        error_o, intr_rx_o, intr_tx_o;
    logic        ss_ni = 1'b1;
    logic        sclk_i = 1'b0;
    logic        sd_i = 1'b0;
    logic        sd_o, sd_oe_o;

    int tests = 0;
    int failed = 0;

    int n_rxp = 0;
    int n_txp = 0;
    int exp_rxp = 0;
    int exp_txp = 0;

    logic [31:0] m_rx, m_hold;
    bit          m_full, m_empty, m_ovf, m_under;

    int cfg_len = 8;
    bit cfg_lsb, cfg_rxneg, cfg_ie;
    bit oe_low;

    spi_device_core dut (
        .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .be_i(be_i), .we_i(we_i), .re_i(re_i), .error_o(error_o),
        .intr_rx_o(intr_rx_o), .intr_tx_o(intr_tx_o),
        .ss_ni(ss_ni), .sclk_i(sclk_i), .sd_i(sd_i), .sd_o(sd_o), .sd_oe_o(sd_oe_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (intr_rx_o === 1'b1) n_rxp++;
        if (intr_tx_o === 1'b1) n_txp++;
    end

    function automatic logic [31:0] mask_of(input int len);
        if (len >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << len) - 32'd1;
    endfunction

    function automatic logic [31:0] model_status();
        return {27'd0, 1'b0, m_under, m_ovf, m_empty, m_full};
    endfunction

    task automatic model_reset();
        m_rx = '0; m_hold = '0; m_full = 0; m_empty = 1; m_ovf = 0; m_under = 0;
    endtask

    task automatic model_load(output logic [31:0] cur, output bit zero);
        if (!m_empty) begin
            cur = m_hold; zero = 0; m_empty = 1;
            if (cfg_ie) exp_txp++;
        end else begin
            cur = '0; zero = 1;
        end
    endtask

    // frame of nch full chars followed by 'extra' bits of an abandoned char
    task automatic model_frame(input int nch, input int extra, input logic [31:0] c0, input logic [31:0] c1,
                               output logic [31:0] e0, output logic [31:0] e1);
        logic [31:0] cur, mk;
        bit zero;
        mk = mask_of(cfg_len);
        e0 = '0; e1 = '0;
        model_load(cur, zero);
        for (int k = 0; k < nch; k++) begin
            if (zero) m_under = 1;
            if (k == 0) e0 = cur & mk; else e1 = cur & mk;
            if (m_full) m_ovf = 1;
            m_rx = ((k == 0) ? c0 : c1) & mk;
            m_full = 1;
            if (cfg_ie) exp_rxp++;
            model_load(cur, zero);
        end
        if (extra > 0 && zero) m_under = 1;
    endtask

    task automatic do_reset();
        rst_i = 1; ss_ni = 1; sclk_i = 0; sd_i = 0; we_i = 0; re_i = 0;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        model_reset();
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] v, input logic [3:0] be);
        @(posedge clk); #1;
        addr_i = {3'b000, a, 2'b00}; wdata_i = v; be_i = be; we_i = 1;
        @(posedge clk); #1;
        we_i = 0; be_i = '0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        addr_i = {3'b000, a, 2'b00}; re_i = 1;
        @(posedge clk); #1;
        re_i = 0;
        d = rdata_o;
    endtask

    task automatic configure(input int len, input bit lsb, input bit rxneg, input bit ie);
        logic [31:0] w;
        cfg_len = len; cfg_lsb = lsb; cfg_rxneg = rxneg; cfg_ie = ie;
        sclk_i = rxneg;
        repeat (4) @(posedge clk);
        w = '0;
        w[4:0] = (len == 32) ? 5'd0 : 5'(len);
        w[8] = 1; w[9] = rxneg; w[10] = ~rxneg; w[11] = lsb; w[12] = ie;
        reg_write(3'd2, w, 4'hF);
    endtask

    task automatic tx_write(input logic [31:0] v);
        reg_write(3'd1, v, 4'hF);
        m_hold = v; m_empty = 0;
    endtask

    task automatic ss_start();
        oe_low = 0;
        ss_ni = 0;
        repeat (H) @(posedge clk);
        #1;
    endtask

    task automatic ss_stop();
        repeat (H) @(posedge clk);
        #1 ss_ni = 1;
        repeat (2 * H) @(posedge clk);
        #1;
    endtask

    // master: present MOSI, take the sampling transition (reading MISO there), return sclk to idle
    task automatic send_bits(input logic [31:0] c, input int nbits, output logic [31:0] miso);
        int idx;
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = cfg_lsb ? i : cfg_len - 1 - i;
            sd_i = c[idx];
            repeat (H) @(posedge clk);
            #1 sclk_i = ~cfg_rxneg;
            miso[idx] = sd_o;
            if (sd_oe_o !== 1'b1) oe_low = 1;
            repeat (H) @(posedge clk);
            #1 sclk_i = cfg_rxneg;
        end
    endtask

    task automatic run_frame(input int nch, input int extra, input logic [31:0] c0, input logic [31:0] c1,
                             output logic [31:0] m0, output logic [31:0] m1);
        logic [31:0] junk;
        m0 = '0; m1 = '0;
        ss_start();
        if (nch >= 1) send_bits(c0, cfg_len, m0);
        if (nch >= 2) send_bits(c1, cfg_len, m1);
        if (extra > 0) send_bits(c0, extra, junk);
        ss_stop();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        tests++; if (rdata_o !== 32'd0) begin failed++; $display("FAIL reset_rdata got %h exp 0", rdata_o); end
        tests++; if ({intr_rx_o, intr_tx_o} !== 2'b00) begin failed++; $display("FAIL reset_intr got %b exp 00", {intr_rx_o, intr_tx_o}); end
        tests++; if ({sd_o, sd_oe_o} !== 2'b00) begin failed++; $display("FAIL reset_sd got %b exp 00", {sd_o, sd_oe_o}); end
        tests++; if (error_o !== 1'b0) begin failed++; $display("FAIL reset_error got %b exp 0", error_o); end
        reg_read(3'd0, d);
        tests++; if (d !== 32'd0) begin failed++; $display("FAIL reset_rx got %h exp 0", d); end
        reg_read(3'd2, d);
        tests++; if (d !== 32'd0) begin failed++; $display("FAIL reset_ctrl got %h exp 0", d); end
        reg_read(3'd3, d);
        tests++; if (d !== 32'h2) begin failed++; $display("FAIL reset_status got %h exp 2", d); end
    endtask

    task automatic test_mode0();
        logic [31:0] d, m0, m1, e0, e1;
        do_reset();
        configure(8, 0, 0, 1);
        reg_read(3'd2, d);
        tests++; if (d !== 32'h1508) begin failed++; $display("FAIL mode0_ctrl got %h exp 1508", d); end
        tx_write(32'hA5);
        model_frame(1, 0, 32'h3C, 0, e0, e1);
        run_frame(1, 0, 32'h3C, 0, m0, m1);
        tests++; if (m0 !== 32'hA5 || m0 !== e0) begin failed++; $display("FAIL mode0_miso got %h exp %h", m0, e0); end
        tests++; if (oe_low) begin failed++; $display("FAIL mode0_oe got low exp high"); end
        reg_read(3'd3, d);
        tests++; if (d !== 32'h3) begin failed++; $display("FAIL mode0_status got %h exp 3", d); end
        reg_read(3'd0, d); m_full = 0;
        tests++; if (d !== 32'h3C) begin failed++; $display("FAIL mode0_rx got %h exp 3c", d); end
        tests++; if (n_rxp !== exp_rxp || n_txp !== exp_txp) begin failed++; $display("FAIL mode0_pulses got %0d/%0d exp %0d/%0d", n_rxp, n_txp, exp_rxp, exp_txp); end
        reg_read(3'd3, d);
        tests++; if (d !== model_status()) begin failed++; $display("FAIL mode0_rxclr got %h exp %h", d, model_status()); end
    endtask

    task automatic test_lsb32();
        logic [31:0] d, m0, m1, e0, e1;
        do_reset();
        configure(32, 1, 0, 1);
        tx_write(32'h1234_5678);
        model_frame(1, 0, 32'hDEAD_BEEF, 0, e0, e1);
        run_frame(1, 0, 32'hDEAD_BEEF, 0, m0, m1);
        tests++; if (m0 !== e0) begin failed++; $display("FAIL lsb32_miso got %h exp %h", m0, e0); end
        reg_read(3'd0, d); m_full = 0;
        tests++; if (d !== 32'hDEAD_BEEF) begin failed++; $display("FAIL lsb32_rx got %h exp deadbeef", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, m0, m1, e0, e1;
        do_reset();
        configure(8, 0, 0, 1);
        tx_write(32'h5C);
        model_frame(2, 0, 32'h11, 32'h22, e0, e1);
        run_frame(2, 0, 32'h11, 32'h22, m0, m1);
        tests++; if (m0 !== e0 || m1 !== 32'h0) begin failed++; $display("FAIL b2b_miso got %h,%h exp %h,0", m0, m1, e0); end
        reg_read(3'd3, d);
        tests++; if (d !== 32'hF || d !== model_status()) begin failed++; $display("FAIL b2b_status got %h exp f", d); end
        reg_read(3'd0, d); m_full = 0;
        tests++; if (d !== 32'h22) begin failed++; $display("FAIL b2b_rx got %h exp 22", d); end
        tests++; if (n_rxp !== exp_rxp || n_txp !== exp_txp) begin failed++; $display("FAIL b2b_pulses got %0d/%0d exp %0d/%0d", n_rxp, n_txp, exp_rxp, exp_txp); end
    endtask

    task automatic test_abort();
        logic [31:0] d, m0, m1, e0, e1, junk;
        int cyc;
        do_reset();
        configure(8, 0, 0, 1);
        tx_write(32'h0F);
        model_frame(1, 0, 32'h5A, 0, e0, e1);
        run_frame(1, 0, 32'h5A, 0, m0, m1);
        reg_read(3'd0, d); m_full = 0;
        tests++; if (d !== 32'h5A) begin failed++; $display("FAIL abort_first_rx got %h exp 5a", d); end
        model_frame(0, 5, 32'h33, 0, e0, e1);
        ss_start();
        send_bits(32'h33, 5, junk);
        ss_ni = 1;
        cyc = 0;
        while (sd_oe_o !== 1'b0 && cyc < 5) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++; if (cyc > 4) begin failed++; $display("FAIL abort_oe got %0d cycles exp <=4", cyc); end
        repeat (H) @(posedge clk);
        reg_read(3'd0, d);
        tests++; if (d !== 32'h5A) begin failed++; $display("FAIL abort_rx got %h exp 5a", d); end
        reg_read(3'd3, d);
        tests++; if (d !== model_status()) begin failed++; $display("FAIL abort_status got %h exp %h", d, model_status()); end
        tests++; if (n_rxp !== exp_rxp) begin failed++; $display("FAIL abort_rxpulse got %0d exp %0d", n_rxp, exp_rxp); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, m0, m1, e0, e1, junk;
        do_reset();
        configure(8, 0, 0, 1);
        tx_write(32'hE7);
        model_frame(0, 3, 32'hAA, 0, e0, e1);
        ss_start();
        send_bits(32'hAA, 3, junk);
        @(posedge clk); #1 rst_i = 1;
        @(posedge clk); #1;
        tests++; if ({sd_oe_o, sd_o, intr_rx_o, intr_tx_o, rdata_o} !== 36'd0) begin failed++; $display("FAIL rstmid_outputs got %b %h exp 0", {sd_oe_o, sd_o, intr_rx_o, intr_tx_o}, rdata_o); end
        rst_i = 0;
        model_reset();
        reg_read(3'd3, d);
        tests++; if (d !== 32'h2) begin failed++; $display("FAIL rstmid_status got %h exp 2", d); end
        reg_read(3'd2, d);
        tests++; if (d !== 32'h0) begin failed++; $display("FAIL rstmid_ctrl got %h exp 0", d); end
        ss_stop();
        configure(8, 0, 0, 1);
        tx_write(32'h96);
        model_frame(1, 0, 32'hC3, 0, e0, e1);
        run_frame(1, 0, 32'hC3, 0, m0, m1);
        tests++; if (m0 !== e0) begin failed++; $display("FAIL rstmid_miso got %h exp %h", m0, e0); end
        reg_read(3'd0, d); m_full = 0;
        tests++; if (d !== 32'hC3) begin failed++; $display("FAIL rstmid_rx got %h exp c3", d); end
        tests++; if (n_rxp !== exp_rxp || n_txp !== exp_txp) begin failed++; $display("FAIL rstmid_pulses got %0d/%0d exp %0d/%0d", n_rxp, n_txp, exp_rxp, exp_txp); end
    endtask

    task automatic test_ie0();
        logic [31:0] d, m0, m1, e0, e1;
        do_reset();
        configure(8, 0, 0, 0);
        tx_write(32'h3A);
        model_frame(2, 0, 32'h81, 32'h7E, e0, e1);
        run_frame(2, 0, 32'h81, 32'h7E, m0, m1);
        tests++; if (n_rxp !== exp_rxp || n_txp !== exp_txp) begin failed++; $display("FAIL ie0_pulses got %0d/%0d exp %0d/%0d", n_rxp, n_txp, exp_rxp, exp_txp); end
        reg_read(3'd3, d);
        tests++; if (d !== 32'hF) begin failed++; $display("FAIL ie0_status got %h exp f", d); end
        reg_write(3'd3, 32'h4, 4'h1); m_ovf = 0;
        reg_read(3'd3, d);
        tests++; if (d !== 32'hB || d !== model_status()) begin failed++; $display("FAIL ie0_w1c got %h exp b", d); end
        reg_read(3'd0, d); m_full = 0;
        tests++; if (d !== 32'h7E) begin failed++; $display("FAIL ie0_rx got %h exp 7e", d); end
    endtask

    task automatic test_random();
        logic [31:0] d, m0, m1, e0, e1, c0, c1;
        int len, nch, extra;
        do_reset();
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 32);
            configure(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) != 0) tx_write($urandom());
            c0 = $urandom(); c1 = $urandom();
            nch = $urandom_range(1, 2);
            extra = (len > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : 0;
            model_frame(nch, extra, c0, c1, e0, e1);
            run_frame(nch, extra, c0, c1, m0, m1);
            tests++; if (m0 !== e0 || m1 !== e1) begin failed++; $display("FAIL rand%0d_miso got %h,%h exp %h,%h", it, m0, m1, e0, e1); end
            reg_read(3'd3, d);
            tests++; if (d !== model_status()) begin failed++; $display("FAIL rand%0d_status got %h exp %h", it, d, model_status()); end
            reg_read(3'd0, d); m_full = 0;
            tests++; if (d !== m_rx) begin failed++; $display("FAIL rand%0d_rx got %h exp %h", it, d, m_rx); end
            tests++; if (n_rxp !== exp_rxp || n_txp !== exp_txp) begin failed++; $display("FAIL rand%0d_pulses got %0d/%0d exp %0d/%0d", it, n_rxp, n_txp, exp_rxp, exp_txp); end
            reg_write(3'd3, 32'hD, 4'h1); m_ovf = 0; m_under = 0;
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_lsb32();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_ie0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired before the sequence completed");
        $display("[TB] %0d tests run, %0d failed", tests + 1, failed + 1);
        $fatal(1, "watchdog");
    end

endmodule
